stable_matching_checker: RTL and testbench
==========================================

# stable_matching_checker

Sequential stability verifier for the output of the stable matching core. It reads the packed preference word `g` and the final match list, then walks every proposer's preference list one entry per cycle. It reports whether the matching is stable, or returns the first blocking pair it finds. It sits downstream of the matching core as the reader/validator of that core's result, and is used for self-check in simulation and for optional on-chip result validation.

## Interface
Parameters:
- `Kr`, 10: number of preferences per B-member (`rPref` list length).
- `Ks`, 10: number of preferences per A-member (`sPref` list length).
- `S`, 10: number of A-members; S >= 2.
- `R`, 10: number of B-members; R >= 2.

Derived widths: logS = log2(S), logR = log2(R), logKs = log2(Ks).

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a check; honoured only in IDLE.
- `g`  in  R*Kr*logS+S*Ks*logR  preference word.
  - rPref entry (r,j) at bit logS*(Kr*r+j), logS bits wide.
  - sPref entry (s,j) at bit R*Kr*logS+logR*(Ks*s+j), logR bits wide.
- `match_list`  in  R*logS  partner of r at bit logS*r.
- `r_valid`  in  R  bit r = 1 means r is matched.
- `busy`  out  1  check in progress.
- `done`  out  1  one-cycle completion pulse.
- `stable`  out  1  result, held until the next accepted start.
- `blk_found`  out  1  a blocking pair was found.
- `blk_s`  out  logS  A-member of the first blocking pair.
- `blk_r`  out  logR  B-member of the first blocking pair.
- `dup_err`  out  1  duplicate-partner error (see Configuration).

`g`, `match_list` and `r_valid` must be held stable from the accepted start until `done`. They are not latched.

## Operation
- FSM states: IDLE, DUP (macro only), SCAN, FIN.
  - IDLE to SCAN (or DUP) on `start`. Index registers are cleared: s=0, k=0 (or rd=0).
  - FIN lasts one cycle: it pulses `done` and returns to IDLE.
- SCAN evaluates one pair per cycle: s, r = sPref[s][k].
  - If r_valid[r] and match_list[r]==s: r is s's partner. Advance to s+1, k=0.
  - Else r is blocking if r_valid[r]==0, or if s precedes its current partner s1 = match_list[r] in rPref[r].
  - "Precedes": find the first index j where exactly one of (rPref[r][j]==s, rPref[r][j]==s1) holds; blocking if that one is s. If s is absent from rPref[r], or s==s1, the pair is not blocking.
  - On a blocking pair: latch blk_s/blk_r, set blk_found=1, stable=0, go to FIN. This is early exit.
  - Else if k==Ks-1 (s is unmatched and the list is exhausted), advance s. Else k+1.
  - When s==S-1 advances, set stable=1 and go to FIN.
- Out-of-range sPref entries (r >= R) are treated as non-blocking and are skipped.
- `start` while busy is ignored.
- `start` asserted in FIN is also ignored. It is accepted in the next cycle, when the block is in IDLE.

## Timing
- Reset: state IDLE. `busy`, `done`, `stable`, `blk_found`, `blk_s`, `blk_r` and `dup_err` are all 0.
- Reset mid-operation aborts immediately. All outputs return to their reset values.
- Start accepted in cycle 0. `busy`=1 from cycle 1 up to and including the FIN cycle.
- SCAN runs E cycles, where E is the number of evaluated pairs; 1 <= E <= S*Ks. `done` pulses in cycle E+1 (R+E+1 with DUP).
- `stable`/`blk_*` update in the FIN cycle and hold until the next accepted start. They are cleared to 0 in the cycle the start is accepted.
- Rank comparison is combinational within the SCAN cycle. No pipelining.

## Configuration
- `STABLE_CHECK_DUP_EN` defined:
  - A DUP phase of R cycles runs first. It checks entry rd against all valid entries rd' > rd for an equal partner.
  - On a hit: dup_err=1, stable=0, SCAN is skipped, go to FIN.
- Undefined: the DUP state is absent, `dup_err` is tied 0, and latency is E+1.

## Structure
- Package `stable_matching_pkg` holds:
  - the `log2` function;
  - width helpers for logS/logR/logKs;
  - g field-offset functions;
  - the FSM state enum.
- Sub-module `rank_compare` (combinational, parameter Kr, logS): inputs are the rPref row, s and s1; output is `prefer`. It shares its first-difference logic with the core's `better` computation.

## Test plan
Scenarios 1–5 use S=R=Ks=Kr=2 with sPref s0=[r0,r1], s1=[r1,r0] and rPref r0=[s0,s1], r1=[s1,s0], unless stated otherwise.
1. Match r0→s0, r1→s1, r_valid=11 → E=2; `done` at cycle 3; stable=1, blk_found=0.
2. Match r0→s1, r1→s0, r_valid=11 → blocking (0,0) at E=1; `done` at cycle 2; stable=0, blk_s=0, blk_r=0.
3. r_valid=00 → blocking (0,0); `done` at cycle 2; stable=0.
4. Preference and match changes:
   - sPref s0=[r1,r0]; rPref r1=[s1,s1].
   - Match r0→s0, r1→s1, r_valid=11.
   - Expected: s0 is absent from r1's list, so not blocking. E=3; `done` at cycle 4; stable=1.
5. Control corner cases (scenario 1 inputs):
   - Pulse `start` at cycle 1 → ignored; a single `done`.
   - Assert `rst_n`=0 at cycle 2 → all outputs 0, state IDLE.
   - Restart → `done` 3 cycles later, stable=1.
6. With `STABLE_CHECK_DUP_EN`:
   - Match r0→s0, r1→s0, r_valid=11 → dup_err=1, stable=0, `done` at cycle R+1=3.
   - Scenario 1 inputs → `done` at cycle 5, stable=1.

Source files
------------

// File: rtl/stable_matching_pkg.sv
// ----------------------------------------------------------------------------
// stable_matching_pkg
//
// Shared definitions for the stable matching checker:
//   - log2()         : ceiling log2, never less than 1 (used for index widths)
//   - log_s/log_r/log_ks : width helpers for A-member, B-member and pref index
//   - g_width()      : total width of the packed preference word g
//   - rpref_lsb()    : LSB of rPref entry (r,j) inside g
//   - spref_lsb()    : LSB of sPref entry (s,j) inside g
//   - state_t        : checker FSM state encoding
//
// Optional feature macro: STABLE_CHECK_DUP_EN adds the DUP state used by the
// duplicate-partner pre-check.
// ----------------------------------------------------------------------------
package stable_matching_pkg;

    // Ceiling log2 with a floor of 1 so that a 2-entry index is 1 bit wide.
    function automatic int log2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int log_s(input int s_count);
        return log2(s_count);
    endfunction

    function automatic int log_r(input int r_count);
        return log2(r_count);
    endfunction

    function automatic int log_ks(input int ks_count);
        return log2(ks_count);
    endfunction

    function automatic int g_width(input int r_count, input int kr, input int s_count,
                                   input int ks);
        return r_count * kr * log_s(s_count) + s_count * ks * log_r(r_count);
    endfunction

    // rPref rows sit at the bottom of g, one logS-wide entry per slot.
    function automatic int rpref_lsb(input int kr, input int lgs, input int r, input int j);
        return lgs * (kr * r + j);
    endfunction

    // sPref rows follow the complete rPref block.
    function automatic int spref_lsb(input int r_count, input int kr, input int lgs,
                                     input int lgr, input int ks, input int s, input int j);
        return r_count * kr * lgs + lgr * (ks * s + j);
    endfunction

`ifdef STABLE_CHECK_DUP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2,
        ST_DUP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/rank_compare.sv
// ----------------------------------------------------------------------------
// rank_compare
//
// Combinational preference test on one B-member's rPref row: does s rank
// ahead of s1? Walks the row from the front and stops at the first slot where
// exactly one of (slot==s, slot==s1) is true; prefer is set when that slot
// names s. If s is absent, or s==s1, prefer stays 0. This is the same
// first-difference rule the matching core uses for its 'better' decision.
//
// Ports:
//   row    in  Kr*logS  rPref row, entry j at bit logS*j
//   s      in  logS     candidate A-member
//   s1     in  logS     current partner
//   prefer out 1        s strictly precedes s1 in row
// ----------------------------------------------------------------------------
module rank_compare #(
    parameter int Kr   = 10,
    parameter int logS = 4
) (
    input  logic [Kr*logS-1:0] row,
    input  logic [logS-1:0]    s,
    input  logic [logS-1:0]    s1,
    output logic               prefer
);

    logic decided;

    always_comb begin
        prefer  = 1'b0;
        decided = 1'b0;
        for (int j = 0; j < Kr; j++) begin
            if (!decided &&
                ((row[j*logS +: logS] == s) != (row[j*logS +: logS] == s1))) begin
                decided = 1'b1;
                prefer  = (row[j*logS +: logS] == s);
            end
        end
    end

endmodule

// File: rtl/stable_matching_checker.sv
// ----------------------------------------------------------------------------
// stable_matching_checker
//
// Sequential stability verifier for the matching core's result. After start it
// walks each A-member's sPref list, one (s, r) pair per cycle, and stops at the
// first blocking pair or after the last A-member has been resolved.
//
// Optional feature macro: STABLE_CHECK_DUP_EN
//   When defined, an R-cycle DUP phase runs first and flags any two valid
//   B-members sharing a partner (dup_err); SCAN is then skipped.
//   When undefined, dup_err is tied 0 and the DUP state does not exist.
//
// Ports:
//   clk        in  1                   clock
//   rst_n      in  1                   asynchronous active-low reset
//   start      in  1                   begin a check (IDLE only)
//   g          in  R*Kr*logS+S*Ks*logR packed preference word
//   match_list in  R*logS              partner of r at bit logS*r
//   r_valid    in  R                   r is matched
//   busy       out 1                   check in progress (through FIN)
//   done       out 1                   one-cycle completion pulse
//   stable     out 1                   matching is stable
//   blk_found  out 1                   a blocking pair was found
//   blk_s      out logS                A-member of first blocking pair
//   blk_r      out logR                B-member of first blocking pair
//   dup_err    out 1                   duplicate partner detected
//
// g, match_list and r_valid are not latched; they must hold until done.
// ----------------------------------------------------------------------------
module stable_matching_checker
    import stable_matching_pkg::*;
#(
    parameter int Kr = 10,
    parameter int Ks = 10,
    parameter int S  = 10,
    parameter int R  = 10,
    localparam int LOG_S  = log_s(S),
    localparam int LOG_R  = log_r(R),
    localparam int LOG_KS = log_ks(Ks),
    localparam int G_W    = g_width(R, Kr, S, Ks)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [G_W-1:0]     g,
    input  logic [R*LOG_S-1:0] match_list,
    input  logic [R-1:0]       r_valid,
    output logic               busy,
    output logic               done,
    output logic               stable,
    output logic               blk_found,
    output logic [LOG_S-1:0]   blk_s,
    output logic [LOG_R-1:0]   blk_r,
    output logic               dup_err
);

    state_t state, state_next;

    logic [LOG_S-1:0]  s_idx;
    logic [LOG_KS-1:0] k_idx;

    // Unpacked views of the preference word and match list.
    logic [LOG_R-1:0]    spref [S][Ks];
    logic [Kr*LOG_S-1:0] rpref_row [R];
    logic [LOG_S-1:0]    match_arr [R];

    for (genvar si = 0; si < S; si++) begin : g_spref_s
        for (genvar sj = 0; sj < Ks; sj++) begin : g_spref_j
            assign spref[si][sj] = g[spref_lsb(R, Kr, LOG_S, LOG_R, Ks, si, sj) +: LOG_R];
        end
    end

    for (genvar ri = 0; ri < R; ri++) begin : g_rrow
        assign rpref_row[ri] = g[rpref_lsb(Kr, LOG_S, ri, 0) +: Kr*LOG_S];
        assign match_arr[ri] = match_list[LOG_S*ri +: LOG_S];
    end

    // Evaluation of the current (s, r) pair.
    logic [LOG_R-1:0] cur_r;
    logic [LOG_S-1:0] partner;
    logic             in_range;
    logic             cur_valid;
    logic             is_partner;
    logic             prefer;
    logic             blocking;
    logic             last_k;
    logic             last_s;
    logic             advance_s;

    assign cur_r      = spref[s_idx][k_idx];
    assign in_range   = (int'(cur_r) < R);
    assign cur_valid  = in_range && r_valid[cur_r];
    assign partner    = match_arr[cur_r];
    assign is_partner = cur_valid && (partner == s_idx);
    // Out-of-range entries are never blocking; they just consume a slot.
    assign blocking   = in_range && !is_partner && (!cur_valid || prefer);
    assign last_k     = (k_idx == LOG_KS'(Ks - 1));
    assign last_s     = (s_idx == LOG_S'(S - 1));
    assign advance_s  = is_partner || (!blocking && last_k);

    rank_compare #(
        .Kr   (Kr),
        .logS (LOG_S)
    ) u_rank_compare (
        .row    (rpref_row[cur_r]),
        .s      (s_idx),
        .s1     (partner),
        .prefer (prefer)
    );

`ifdef STABLE_CHECK_DUP_EN
    logic [LOG_R-1:0] rd_idx;
    logic             dup_seen;
    logic             dup_hit;
    logic             last_rd;
    logic             dup_err_q;

    assign last_rd = (rd_idx == LOG_R'(R - 1));

    // Entry rd collides with any later valid entry holding the same partner.
    always_comb begin
        dup_hit = 1'b0;
        for (int j = 0; j < R; j++) begin
            if (r_valid[rd_idx] && (j > int'(rd_idx)) && r_valid[j] &&
                (match_arr[j] == match_arr[rd_idx])) begin
                dup_hit = 1'b1;
            end
        end
    end

    // The DUP phase always runs its full R cycles; a hit is remembered and
    // acted on at the last entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx    <= '0;
            dup_seen  <= 1'b0;
            dup_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rd_idx    <= '0;
                        dup_seen  <= 1'b0;
                        dup_err_q <= 1'b0;
                    end
                end
                ST_DUP: begin
                    rd_idx   <= rd_idx + LOG_R'(1);
                    dup_seen <= dup_seen | dup_hit;
                    if (last_rd && (dup_seen || dup_hit)) begin
                        dup_err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dup_err = dup_err_q;
`else
    assign dup_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef STABLE_CHECK_DUP_EN
                    state_next = ST_DUP;
`else
                    state_next = ST_SCAN;
`endif
                end
            end
`ifdef STABLE_CHECK_DUP_EN
            ST_DUP: begin
                if (last_rd) begin
                    state_next = (dup_seen || dup_hit) ? ST_FIN : ST_SCAN;
                end
            end
`endif
            ST_SCAN: begin
                if (blocking || (advance_s && last_s)) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Scan indices and result registers. Results are cleared when a start is
    // accepted and written on the edge that enters FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_idx     <= '0;
            k_idx     <= '0;
            stable    <= 1'b0;
            blk_found <= 1'b0;
            blk_s     <= '0;
            blk_r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        s_idx     <= '0;
                        k_idx     <= '0;
                        stable    <= 1'b0;
                        blk_found <= 1'b0;
                        blk_s     <= '0;
                        blk_r     <= '0;
                    end
                end
                ST_SCAN: begin
                    if (blocking) begin
                        blk_found <= 1'b1;
                        blk_s     <= s_idx;
                        blk_r     <= cur_r;
                        stable    <= 1'b0;
                    end else if (advance_s) begin
                        if (last_s) begin
                            stable <= 1'b1;
                        end
                        s_idx <= s_idx + LOG_S'(1);
                        k_idx <= '0;
                    end else begin
                        k_idx <= k_idx + LOG_KS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

endmodule

// File: tb/tb_stable_matching_checker.sv
// ----------------------------------------------------------------------------
// tb_stable_matching_checker
//
// Scoreboard bench for stable_matching_checker with S=R=Ks=Kr=2 (all index
// widths 1 bit, g is 8 bits). Stimulus pushes the expected result and the
// cycle at which done must appear; a monitor pops and compares on every done.
//
// g layout for this configuration (bit: meaning):
//   0: rPref r0[0]  1: rPref r0[1]  2: rPref r1[0]  3: rPref r1[1]
//   4: sPref s0[0]  5: sPref s0[1]  6: sPref s1[0]  7: sPref s1[1]
// ----------------------------------------------------------------------------
module tb_stable_matching_checker;

    localparam int P = 2;

`ifdef STABLE_CHECK_DUP_EN
    localparam int DUP_LAT = P;
`else
    localparam int DUP_LAT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] g;
    logic [1:0] match_list;
    logic [1:0] r_valid;
    logic       busy;
    logic       done;
    logic       stable;
    logic       blk_found;
    logic [0:0] blk_s;
    logic [0:0] blk_r;
    logic       dup_err;

    stable_matching_checker #(
        .Kr (P),
        .Ks (P),
        .S  (P),
        .R  (P)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .g          (g),
        .match_list (match_list),
        .r_valid    (r_valid),
        .busy       (busy),
        .done       (done),
        .stable     (stable),
        .blk_found  (blk_found),
        .blk_s      (blk_s),
        .blk_r      (blk_r),
        .dup_err    (dup_err)
    );

    typedef struct {
        string name;
        int    due;
        logic  stable;
        logic  blk_found;
        logic  blk_s;
        logic  blk_r;
        logic  dup_err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic checkOutput(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Issue one check; e is the number of SCAN cycles the pair walk takes.
    task automatic applyStimulus(input string name, input logic [7:0] gv, input logic [1:0] ml,
                                 input logic [1:0] rv, input int e, input logic st,
                                 input logic bf, input logic bs, input logic br,
                                 input logic de);
        exp_t x;
        g          = gv;
        match_list = ml;
        r_valid    = rv;
        start      = 1'b1;
        x.name      = name;
        x.due       = edge_cnt + DUP_LAT + e + 1;
        x.stable    = st;
        x.blk_found = bf;
        x.blk_s     = bs;
        x.blk_r     = br;
        x.dup_err   = de;
        exp_q.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: done not seen, expected within 60 cycles",
                     exp_q[0].name);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_busy"}, int'(busy), 0);
        checkOutput({name, "_done"}, int'(done), 0);
        checkOutput({name, "_stable"}, int'(stable), 0);
        checkOutput({name, "_blk_found"}, int'(blk_found), 0);
        checkOutput({name, "_blk_s"}, int'(blk_s), 0);
        checkOutput({name, "_blk_r"}, int'(blk_r), 0);
        checkOutput({name, "_dup_err"}, int'(dup_err), 0);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL spurious_done: got done=1 at cycle %0d, expected none",
                         edge_cnt);
            end else begin
                e = exp_q.pop_front();
                checkOutput({e.name, "_done_cycle"}, edge_cnt, e.due);
                checkOutput({e.name, "_stable"}, int'(stable), int'(e.stable));
                checkOutput({e.name, "_blk_found"}, int'(blk_found), int'(e.blk_found));
                checkOutput({e.name, "_blk_s"}, int'(blk_s), int'(e.blk_s));
                checkOutput({e.name, "_blk_r"}, int'(blk_r), int'(e.blk_r));
                checkOutput({e.name, "_dup_err"}, int'(dup_err), int'(e.dup_err));
            end
        end
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        g          = 8'h00;
        match_list = 2'b00;
        r_valid    = 2'b00;
        #3;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Base prefs 0x66: s0=[r0,r1], s1=[r1,r0], r0=[s0,s1], r1=[s1,s0].
        applyStimulus("s1_stable", 8'h66, 2'b10, 2'b11, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitDrain();
        applyStimulus("s2_swap", 8'h66, 2'b01, 2'b11, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitDrain();
        applyStimulus("s3_none", 8'h66, 2'b10, 2'b00, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitDrain();
        // s0=[r1,r0], r1=[s1,s1]: s0 absent from r1's list.
        applyStimulus("s4_absent", 8'h5E, 2'b10, 2'b11, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitDrain();
        // s0=s1=[r0,r1], r0=[s1,s0]: s1 steals r0.
        applyStimulus("blk_s1_r0", 8'hA5, 2'b10, 2'b11, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        waitDrain();
        // s0=s1=[r1,r0], r0=r1=[s0,s1]: s0 steals r1 on its first try.
        applyStimulus("blk_s0_r1", 8'h5A, 2'b10, 2'b11, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        waitDrain();
        // Only r0 matched; s1 reaches unmatched r1.
        applyStimulus("blk_s1_r1", 8'h66, 2'b10, 2'b01, 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        waitDrain();
        // s1=[r0,r0] unmatched, exhausts its list without blocking.
        applyStimulus("exhaust", 8'h26, 2'b00, 2'b01, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitDrain();

        // Start pulses while busy and during FIN must be ignored.
        applyStimulus("s5_ignore", 8'h66, 2'b10, 2'b11, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s5_busy_cycle1", int'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("s5_fin_reached", int'(done), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain();
        repeat (4) @(negedge clk);
        checkOutput("s5_idle_busy", int'(busy), 0);
        checkOutput("s5_held_stable", int'(stable), 1);

        // Reset in the middle of a check aborts it.
        g          = 8'h66;
        match_list = 2'b10;
        r_valid    = 2'b11;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkAllZero("s5_abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus("s5_restart", 8'h66, 2'b10, 2'b11, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitDrain();

`ifdef STABLE_CHECK_DUP_EN
        // Both B-members claim s0: DUP phase runs R cycles then FIN.
        applyStimulus("s6_dup", 8'h66, 2'b00, 2'b11, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        waitDrain();
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
